hwag_vr_capture: RTL and testbench

Upstream front end of `hwag`. Conditions the raw VR crank-sensor input with a synchronizer, glitch filter and edge detector. Measures the tooth period in `clk` cycles, detects the missing-tooth gap and locks onto the wheel pattern. Hands `hwag` a per-tooth strobe, period, tooth index and sync flag, replacing the raw `vr_in` decode.

---
 rtl/hwag_pkg.sv | 15 +
 rtl/hwag_vr_capture_vr_filter.sv | 51 +++++
 rtl/hwag_vr_capture.sv | 138 +++++++++++++
 tb/tb_hwag_vr_capture.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared types and constants for the hwag crank-wheel front end and its consumers.
package hwag_pkg;

  // Default width of the period counter and of every period value.
  localparam int HWAG_CAP_W = 24;

  // Wheel-pattern lock states of the VR capture front end.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_CHECK,
    ST_SYNC
  } vrcap_state_t;

endpackage

// File: rtl/hwag_vr_capture_vr_filter.sv
// VR input conditioning: two-flop synchronizer, run-length glitch filter and
// a one-cycle edge event for the selected polarity of the filtered signal.
module vr_filter #(
  parameter int FILT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vr_in,
  input  logic              edge_sel,
  input  logic [FILT_W-1:0] filt_len,
  output logic              edge_ev
);

  logic              sync_p0;
  logic              sync_p1;
  logic              filt;
  logic              filt_d;
  logic [FILT_W-1:0] run_cnt;
  logic [FILT_W-1:0] len_eff;

  // A zero length would never let the filter move, so it behaves as one sample.
  assign len_eff = (filt_len == '0) ? FILT_W'(1) : filt_len;

  // Synchronize, count disagreeing samples, toggle after len_eff of them, flag the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      run_cnt <= '0;
      edge_ev <= 1'b0;
    end else begin
      sync_p0 <= vr_in;
      sync_p1 <= sync_p0;
      if (sync_p1 != filt) begin
        if (run_cnt >= len_eff - FILT_W'(1)) begin
          filt    <= sync_p1;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + FILT_W'(1);
        end
      end else begin
        run_cnt <= '0;
      end
      filt_d  <= filt;
      edge_ev <= (filt != filt_d) && (filt == edge_sel);
    end
  end

endmodule

// File: rtl/hwag_vr_capture.sv
// VR crank-sensor capture: conditions vr_in, measures tooth periods in clk
// cycles, finds the missing-tooth gap and locks onto the wheel pattern.
module hwag_vr_capture
  import hwag_pkg::*;
#(
  parameter int FILT_W = 8,
  parameter int CAP_W  = HWAG_CAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vr_in,
  input  logic              edge_sel,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CAP_W-1:0]  cap_min,
  input  logic [CAP_W-1:0]  cap_max,
  input  logic [7:0]        thnb,
  output logic              tooth_stb,
  output logic [CAP_W-1:0]  tooth_period,
  output logic              gap_stb,
  output logic [7:0]        tooth_idx,
  output logic              sync,
  output logic              err_short,
  output logic              err_sync,
  output logic              stall
);

  logic             edge_ev;
  logic [CAP_W-1:0] cnt_p0;
  logic [CAP_W-1:0] pprev;
  logic             pprev_vld;
  logic             gap_hit;
  vrcap_state_t     state;

  // Period counter step: count up but never past the stall threshold.
  function automatic logic [CAP_W-1:0] sat_inc(input logic [CAP_W-1:0] v,
                                               input logic [CAP_W-1:0] lim);
    return (v >= lim) ? lim : v + CAP_W'(1);
  endfunction

  // Gap when the new period is at least twice the previous one; one extra bit avoids overflow.
  function automatic logic is_gap(input logic [CAP_W-1:0] p, input logic [CAP_W-1:0] pp);
    return {1'b0, p} >= {pp, 1'b0};
  endfunction

  vr_filter #(.FILT_W(FILT_W)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .vr_in    (vr_in),
    .edge_sel (edge_sel),
    .filt_len (filt_len),
    .edge_ev  (edge_ev)
  );

  assign gap_hit = pprev_vld && is_gap(cnt_p0, pprev);

  // Period measurement, edge acceptance, stall detection and wheel-lock FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt_p0       <= '0;
      pprev        <= '0;
      pprev_vld    <= 1'b0;
      tooth_stb    <= 1'b0;
      tooth_period <= '0;
      gap_stb      <= 1'b0;
      tooth_idx    <= '0;
      sync         <= 1'b0;
      err_short    <= 1'b0;
      err_sync     <= 1'b0;
      stall        <= 1'b0;
    end else begin
      tooth_stb <= 1'b0;
      gap_stb   <= 1'b0;
      err_short <= 1'b0;
      err_sync  <= 1'b0;
      stall     <= 1'b0;
      if (state == ST_IDLE) begin
        // Unarmed: the first edge only starts the period counter.
        cnt_p0 <= '0;
        if (edge_ev) begin
          cnt_p0    <= CAP_W'(1);
          pprev_vld <= 1'b0;
          state     <= ST_SEEK;
        end
      end else if (edge_ev && (cnt_p0 < cap_min)) begin
        err_short <= 1'b1;
        cnt_p0    <= sat_inc(cnt_p0, cap_max);
      end else if (edge_ev) begin
        cnt_p0       <= CAP_W'(1);
        tooth_stb    <= 1'b1;
        tooth_period <= cnt_p0;
        gap_stb      <= gap_hit;
        pprev        <= cnt_p0;
        pprev_vld    <= 1'b1;
        case (state)
          ST_SEEK: begin
            if (gap_hit) begin
              state     <= ST_CHECK;
              tooth_idx <= '0;
            end
          end
          ST_CHECK, ST_SYNC: begin
            if (gap_hit) begin
              tooth_idx <= '0;
              if (tooth_idx == thnb) begin
                state <= ST_SYNC;
                sync  <= 1'b1;
              end else begin
                err_sync <= 1'b1;
                state    <= ST_CHECK;
                sync     <= 1'b0;
              end
            end else if (tooth_idx == thnb) begin
              err_sync  <= 1'b1;
              state     <= ST_SEEK;
              sync      <= 1'b0;
              tooth_idx <= '0;
            end else begin
              tooth_idx <= tooth_idx + 8'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (cnt_p0 == cap_max) begin
        // No edge within cap_max cycles: the wheel stopped, drop the lock.
        stall     <= 1'b1;
        state     <= ST_IDLE;
        sync      <= 1'b0;
        tooth_idx <= '0;
        cnt_p0    <= '0;
        pprev_vld <= 1'b0;
      end else begin
        cnt_p0 <= sat_inc(cnt_p0, cap_max);
      end
    end
  end

endmodule

// File: tb/tb_hwag_vr_capture.sv
// Bench for hwag_vr_capture: timestamp-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_hwag_vr_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        vr_in;
  logic        edge_sel;
  logic [7:0]  filt_len;
  logic [23:0] cap_min;
  logic [23:0] cap_max;
  logic [7:0]  thnb;
  logic        tooth_stb;
  logic [23:0] tooth_period;
  logic        gap_stb;
  logic [7:0]  tooth_idx;
  logic        sync;
  logic        err_short;
  logic        err_sync;
  logic        stall;

  hwag_vr_capture #(.FILT_W(8), .CAP_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .vr_in        (vr_in),
    .edge_sel     (edge_sel),
    .filt_len     (filt_len),
    .cap_min      (cap_min),
    .cap_max      (cap_max),
    .thnb         (thnb),
    .tooth_stb    (tooth_stb),
    .tooth_period (tooth_period),
    .gap_stb      (gap_stb),
    .tooth_idx    (tooth_idx),
    .sync         (sync),
    .err_short    (err_short),
    .err_sync     (err_sync),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      if (n_bad >= 50) begin
        summary();
        $finish;
      end
    end
  endtask

  function automatic logic [37:0] outs();
    return {tooth_stb, gap_stb, err_short, err_sync, stall, sync, tooth_idx, tooth_period};
  endfunction

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_SEEK = 1, M_CHECK = 2, M_SYNC = 3;
  bit          m_started = 0;
  bit          m_s1, m_s2, m_filt, m_tog, m_ev;
  bit          hist[$];
  int          mc = 0;
  int          m_last = 0;
  int          m_state = M_IDLE;
  bit          m_ok = 0;
  longint      m_pprev = 0;
  logic        e_stb = 0, e_gap = 0, e_short = 0, e_esync = 0, e_stall = 0, e_sync = 0;
  logic [7:0]  e_idx = 0;
  logic [23:0] e_period = 0;

  function automatic logic [37:0] e_vec();
    return {e_stb, e_gap, e_short, e_esync, e_stall, e_sync, e_idx, e_period};
  endfunction

  task automatic model_step();
    int     el, lp;
    bit     tog_now, ev_now, gap;
    longint p;
    mc++;
    e_stb = 0; e_gap = 0; e_short = 0; e_esync = 0; e_stall = 0;
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_filt = 0; m_tog = 0; m_ev = 0;
      hist.delete();
      m_state = M_IDLE; m_ok = 0; m_pprev = 0; m_last = mc;
      e_idx = 0; e_sync = 0; e_period = 0;
      m_started = 1;
      return;
    end
    // elapsed cycles since the last accepted edge, clipped at the stall threshold
    el = mc - m_last;
    if (el > cap_max) el = cap_max;
    if (m_state == M_IDLE) begin
      if (m_ev) begin
        m_last = mc; m_state = M_SEEK; m_ok = 0;
      end
    end else if (m_ev && el < cap_min) begin
      e_short = 1;
    end else if (m_ev) begin
      p = el;
      e_stb = 1; e_period = p[23:0];
      gap = m_ok && (p >= 2 * m_pprev);
      e_gap = gap;
      m_pprev = p; m_ok = 1; m_last = mc;
      if (m_state == M_SEEK) begin
        if (gap) begin m_state = M_CHECK; e_idx = 0; end
      end else if (gap) begin
        if (e_idx == thnb) begin m_state = M_SYNC; e_sync = 1; end
        else begin e_esync = 1; m_state = M_CHECK; e_sync = 0; end
        e_idx = 0;
      end else if (e_idx == thnb) begin
        e_esync = 1; m_state = M_SEEK; e_sync = 0; e_idx = 0;
      end else begin
        e_idx = e_idx + 8'd1;
      end
    end else if (el == cap_max) begin
      e_stall = 1; m_state = M_IDLE; e_sync = 0; e_idx = 0; m_ok = 0;
    end
    // filtered edge: the input must disagree with filt for the last lp synced samples
    ev_now = m_tog && (m_filt == edge_sel);
    hist.push_back(m_s2);
    if (hist.size() > 300) void'(hist.pop_front());
    lp = (filt_len == 0) ? 1 : int'(filt_len);
    tog_now = (hist.size() >= lp);
    for (int k = 0; k < lp && tog_now; k++)
      if (hist[hist.size() - 1 - k] == m_filt) tog_now = 0;
    if (tog_now) m_filt = !m_filt;
    m_tog = tog_now;
    m_ev  = ev_now;
    m_s2  = m_s1;
    m_s1  = vr_in;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare and pulse monitor ----------------
  int cnt_stb = 0, cnt_gap = 0, cnt_short = 0, cnt_esync = 0, cnt_stall = 0;
  int last_stb_cyc = 0, stall_cyc = 0, max_idx = 0, prev_idx = 0, idx_before_err = -1;

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      chk("cycle_outputs", {26'd0, outs()}, {26'd0, e_vec()});
      if (tooth_stb) begin cnt_stb++; last_stb_cyc = cyc; end
      if (gap_stb) cnt_gap++;
      if (err_short) cnt_short++;
      if (err_sync) begin cnt_esync++; idx_before_err = prev_idx; end
      if (stall) begin cnt_stall++; stall_cyc = cyc; end
      if (int'(tooth_idx) > max_idx) max_idx = tooth_idx;
      prev_idx = tooth_idx;
    end
  end

  initial begin
    #(10 * 150000);
    n_bad++;
    $display("FAIL watchdog: run still active at cycle %0d, required to end earlier", cyc);
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic tooth(input int p);
    vr_in = 1'b1;
    tick(p / 2);
    vr_in = 1'b0;
    tick(p - p / 2);
  endtask

  task automatic rise_lat(output int lat);
    lat = -1;
    vr_in = 1'b1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (tooth_stb) lat = k;
    end
  endtask

  int t_a, t_b, lat, base_gap, stb0, st0;

  initial begin
    rst = 1'b0; vr_in = 1'b0; edge_sel = 1'b1; filt_len = 8'd3;
    cap_min = 24'd64; cap_max = 24'd5000; thnb = 8'd57;
    tick(2);
    chk("reset_outputs", {26'd0, outs()}, 64'd0);
    tick(1);
    rst = 1'b1;

    // arming edge, then 2-cycle glitches, then a clean step 200 cycles later
    t_a = cyc;
    vr_in = 1'b1; tick(20); vr_in = 1'b0;
    repeat (5) begin tick(10); vr_in = 1'b1; tick(2); vr_in = 1'b0; end
    wait_cyc(t_a + 200);
    chk("no_strobe_from_arm_or_glitches", cnt_stb, 0);
    rise_lat(lat);
    chk("step_latency_filt3", lat, 6);
    tick(50); vr_in = 1'b0;
    chk("period_200", tooth_period, 200);

    // short edge rejection, then accepted periods
    t_b = t_a + 200;
    cap_min = 24'd128;
    wait_cyc(t_b + 100); vr_in = 1'b1; tick(50); vr_in = 1'b0;
    chk("err_short_count", cnt_short, 1);
    chk("no_strobe_on_short", cnt_stb, 1);
    wait_cyc(t_b + 200); vr_in = 1'b1; tick(50); vr_in = 1'b0;
    chk("period_after_reject", tooth_period, 200);
    cap_min = 24'd64;
    wait_cyc(t_b + 300); vr_in = 1'b1; tick(50); vr_in = 1'b0;
    wait_cyc(t_b + 400); vr_in = 1'b1; tick(50); vr_in = 1'b0;
    chk("period_100", tooth_period, 100);
    filt_len = 8'd0;
    wait_cyc(t_b + 500);
    rise_lat(lat);
    chk("step_latency_filt0", lat, 4);
    tick(50); vr_in = 1'b0;
    wait_cyc(t_b + 600); vr_in = 1'b1; tick(50); vr_in = 1'b0;
    filt_len = 8'd3;

    // reset, then 60-2 wheel: lock, drop a tooth, relock
    rst = 1'b0; tick(1);
    chk("reset_mid_run", {26'd0, outs()}, 64'd0);
    tick(1); rst = 1'b1;
    base_gap = cnt_gap;
    repeat (4) tooth(256);
    tooth(768);
    repeat (57) tooth(256);
    tooth(768);
    tooth(256);
    chk("sync_after_second_gap", sync, 1);
    chk("gaps_seen_lock", cnt_gap - base_gap, 2);
    repeat (55) tooth(256);
    tooth(768);
    tooth(256);
    chk("err_sync_count", cnt_esync, 1);
    chk("idx_before_err", idx_before_err, 56);
    chk("sync_dropped", sync, 0);
    chk("idx_after_err", tooth_idx, 0);
    repeat (56) tooth(256);
    tooth(768);
    repeat (5) tooth(256);
    chk("sync_relocked", sync, 1);
    chk("gaps_seen_total", cnt_gap - base_gap, 4);
    chk("max_idx", max_idx, 57);
    chk("idx_in_sync", tooth_idx, 4);

    // one-cycle reset while in SYNC
    rst = 1'b0; tick(1);
    chk("reset_in_sync", {26'd0, outs()}, 64'd0);
    rst = 1'b1;
    stb0 = cnt_stb;
    tooth(256);
    chk("first_edge_after_reset_silent", cnt_stb, stb0);
    tooth(256);
    chk("second_edge_strobes", cnt_stb, stb0 + 1);
    chk("period_256", tooth_period, 256);

    // stall after cap_max idle cycles; an edge on the stall cycle wins
    cap_max = 24'd1000;
    st0 = cnt_stall;
    tick(1100);
    chk("stall_count", cnt_stall, st0 + 1);
    chk("stall_delay", stall_cyc - last_stb_cyc, 1000);
    chk("sync_after_stall", sync, 0);
    stb0 = cnt_stb;
    tooth(300);
    chk("idle_after_stall", cnt_stb, stb0);
    tooth(1000);
    tooth(200);
    chk("period_at_cap_max", tooth_period, 1000);
    chk("no_stall_on_edge", cnt_stall, st0 + 1);
    tick(1200);
    chk("stall_again", cnt_stall, st0 + 2);

    summary();
    $finish;
  end

endmodule
